matmul_scheduler: RTL and testbench
===================================

Name: matmul_scheduler

Overview:
Multi-requester controller for the shared matrix-multiply resource. It arbitrates jobs from NREQ requesters round-robin, latches the winner's dimensions, and sequences the i/j/k loops as a state machine. Each step issues element reads to the A/B operand stores, accumulates one product per step in a single MAC, and writes each finished C element to the result store. It sits between the operation-register decode logic and the A/B/C matrix storage.

Parameters:
NREQ, 2, number of requesters (2..8)
DIM_BITS, 4, width of each dimension field and of every row/col index; max dimension 15
DATA_W, 32, element width of A, B, C and the accumulator

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately
req  input  NREQ  per-requester level job request
req_dims  input  NREQ*3*DIM_BITS  per requester r, slice r holds {N, M, P} with N in the MSBs; C[N][P] = A[N][M] * B[M][P]
grant  output  NREQ  one-hot, one-cycle pulse when requester's job is accepted
done  output  NREQ  one-hot, one-cycle pulse when that requester's job completes
busy  output  1  high from grant cycle through done cycle inclusive
rd_en  output  1  operand read strobe
a_row, a_col  output  DIM_BITS each  A element address (i, k)
b_row, b_col  output  DIM_BITS each  B element address (k, j)
a_data, b_data  input  DATA_W each  operand data, valid exactly 1 cycle after rd_en
c_wr_en  output  1  result write strobe
c_row, c_col  output  DIM_BITS each  C element address (i, j)
c_data  output  DATA_W  result element

Behaviour:
- Reset (reset=0, async): state=IDLE; grant, done, busy, rd_en, c_wr_en = 0; all addresses, c_data, accumulator, i/j/k = 0; round-robin pointer set so requester 0 has top priority. Reset mid-job abandons the job: no done pulse, no further writes.
- States: IDLE, FETCH, ACC, WRITE, DONE.
- IDLE: if any req bit is high, pick the winner, latch its N/M/P, clear i/j/k/acc, and pulse grant[winner] with busy=1 on the next cycle.
  - If N, M or P is 0, go to DONE: grant and done pulse in the same cycle, no reads or writes.
  - Otherwise go to FETCH.
- Arbitration: the first asserted req scanning upward from (last winner + 1) mod NREQ. After reset the scan starts at 0. The pointer updates only on grant.
- Request hold: requesters hold req and req_dims stable until they see grant, then drop req. A req still high when the scheduler returns to IDLE is a new job.
- FETCH (1 cycle): rd_en=1, a=(i,k), b=(k,j); go to ACC.
- ACC (1 cycle): acc <= acc + a_data*b_data, truncated to the low DATA_W bits (unsigned, wrap-around, no saturation).
  - If k==M-1, go to WRITE; else k++ and go to FETCH.
- WRITE (1 cycle): c_wr_en=1, c_row=i, c_col=j, c_data=acc; clear acc and k.
  - If j<P-1: j++. Else j=0, i++.
  - After the last element (i==N-1, j==P-1), go to DONE; else go to FETCH.
- Write order is row-major: j is the inner loop.
- DONE (1 cycle): done[winner]=1, busy=1; go to IDLE (busy=0 next cycle).
- Latency: done is asserted N*P*(2M+1) cycles after grant (1x1x1: grant at t, done at t+3). Reads per job = N*P*M; writes = N*P.
- rd_en and c_wr_en are never high in the same cycle.
- The winner latch persists until the next grant.
- req changes during a job are ignored; new requests wait in IDLE.

Test Plan:
- 1x1x1: A=3, B=5 -> grant at t; rd_en at t; c_wr_en at t+2 with (0,0), data 15; done at t+3; busy high t..t+3.
- 2x2x2: A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> writes in order (0,0)=19, (0,1)=22, (1,0)=43, (1,1)=50; done 20 cycles after grant; 8 reads.
- Overflow: 1x2x1, A=[0xFFFFFFFF, 1], B=[2, 3] -> c_data=0x00000001 (wrapped).
- Arbitration: req=2'b11 held after reset -> req0 granted first; both re-request after done -> req1 granted next, then req0; no grant while busy.
- Zero dimension: dims {N=0, M=3, P=2} -> grant and done in the same cycle, no rd_en or c_wr_en, back to IDLE the next cycle.
- Reset mid-job: assert reset=0 during a 3x3x3 job -> all outputs 0 immediately, no done pulse. After release, req0 gets top priority and a new 1x1x1 job completes normally.

Source files
------------

// File: rtl/matmul_scheduler.sv
// matmul_scheduler: round-robin job arbiter plus i/j/k loop sequencer
// feeding one MAC from the A/B stores and writing C row-major.
module matmul_scheduler #(
  parameter int NREQ     = 2,
  parameter int DIM_BITS = 4,
  parameter int DATA_W   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*3*DIM_BITS-1:0] req_dims,
  output logic [NREQ-1:0]            grant,
  output logic [NREQ-1:0]            done,
  output logic                       busy,
  output logic                       rd_en,
  output logic [DIM_BITS-1:0]        a_row,
  output logic [DIM_BITS-1:0]        a_col,
  output logic [DIM_BITS-1:0]        b_row,
  output logic [DIM_BITS-1:0]        b_col,
  input  logic [DATA_W-1:0]          a_data,
  input  logic [DATA_W-1:0]          b_data,
  output logic                       c_wr_en,
  output logic [DIM_BITS-1:0]        c_row,
  output logic [DIM_BITS-1:0]        c_col,
  output logic [DATA_W-1:0]          c_data
);
  localparam int IW = $clog2(NREQ);
  localparam int JW = 3 * DIM_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ACC, S_WRITE, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0]       r_start;
  logic [IW-1:0]       r_win;
  logic [IW-1:0]       w_win;
  logic [NREQ-1:0]     r_grant;
  logic [DIM_BITS-1:0] r_n, r_m, r_p;
  logic [DIM_BITS-1:0] r_i, r_j, r_k;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   w_prod;
  logic [2*NREQ-1:0]   w_dbl;
  logic [IW:0]         w_sum;
  logic [JW-1:0]       w_dims;
  logic [DIM_BITS-1:0] w_dn, w_dm, w_dp;
  logic                w_found;
  logic                w_zero;
  logic                w_k_last;
  logic                w_j_last;
  logic                w_last;

  // Rotate requests so bit 0 is the current highest-priority requester.
  assign w_dbl = {req, req} >> r_start;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int o = 0; o < NREQ; o++) begin
      if (!w_found && w_dbl[o]) begin
        w_found = 1'b1;
        w_sum   = (IW+1)'(r_start) + (IW+1)'(o);
        if (w_sum >= (IW+1)'(NREQ))
          w_win = IW'(w_sum - (IW+1)'(NREQ));
        else
          w_win = IW'(w_sum);
      end
    end
  end

  always_comb begin
    w_dims = req_dims[JW-1:0];
    for (int r = 1; r < NREQ; r++) begin
      if (w_win == IW'(r))
        w_dims = req_dims[r*JW +: JW];
    end
  end

  assign {w_dn, w_dm, w_dp} = w_dims;
  assign w_zero   = (w_dn == '0) || (w_dm == '0) || (w_dp == '0);
  assign w_k_last = (r_k == r_m - DIM_BITS'(1));
  assign w_j_last = (r_j == r_p - DIM_BITS'(1));
  assign w_last   = w_j_last && (r_i == r_n - DIM_BITS'(1));
  assign w_prod   = a_data * b_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = w_zero ? S_DONE : S_FETCH;
      S_FETCH: w_next = S_ACC;
      S_ACC:   w_next = w_k_last ? S_WRITE : S_FETCH;
      S_WRITE: w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en   = (r_state == S_FETCH);
    c_wr_en = (r_state == S_WRITE);
    busy    = (r_state != S_IDLE);
    done    = '0;
    if (r_state == S_DONE)
      done = NREQ'(1) << r_win;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start <= '0;
      r_win   <= '0;
      r_grant <= '0;
      r_n     <= '0;
      r_m     <= '0;
      r_p     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
    end else begin
      r_grant <= '0;
      case (r_state)
        S_IDLE: if (w_found) begin
          r_n     <= w_dn;
          r_m     <= w_dm;
          r_p     <= w_dp;
          r_win   <= w_win;
          r_start <= (w_win == IW'(NREQ-1)) ? '0 : w_win + IW'(1);
          r_grant <= NREQ'(1) << w_win;
          r_i     <= '0;
          r_j     <= '0;
          r_k     <= '0;
          r_acc   <= '0;
        end
        S_ACC: begin
          r_acc <= r_acc + w_prod;
          if (!w_k_last) r_k <= r_k + DIM_BITS'(1);
        end
        S_WRITE: begin
          r_acc <= '0;
          r_k   <= '0;
          if (w_j_last) begin
            r_j <= '0;
            r_i <= r_i + DIM_BITS'(1);
          end else begin
            r_j <= r_j + DIM_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign grant  = r_grant;
  assign a_row  = r_i;
  assign a_col  = r_k;
  assign b_row  = r_k;
  assign b_col  = r_j;
  assign c_row  = r_i;
  assign c_col  = r_j;
  assign c_data = r_acc;

endmodule

// File: tb/tb_matmul_scheduler.sv
// tb_matmul_scheduler: directed and random jobs checked against a
// plain-arithmetic matrix product and round-robin arbitration model.
module tb_matmul_scheduler;
  localparam int NREQ = 2;
  localparam int DB   = 4;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*3*DB-1:0] req_dims;
  logic [NREQ-1:0]      grant, done;
  logic                 busy, rd_en, c_wr_en;
  logic [DB-1:0]        a_row, a_col, b_row, b_col, c_row, c_col;
  logic [DW-1:0]        a_data, b_data, c_data;

  matmul_scheduler #(.NREQ(NREQ), .DIM_BITS(DB), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_dims(req_dims),
    .grant(grant), .done(done), .busy(busy), .rd_en(rd_en),
    .a_row(a_row), .a_col(a_col), .b_row(b_row), .b_col(b_col),
    .a_data(a_data), .b_data(b_data), .c_wr_en(c_wr_en),
    .c_row(c_row), .c_col(c_col), .c_data(c_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tb_ptr = 0;

  logic [DW-1:0] A [16][16];
  logic [DW-1:0] B [16][16];

  // Operand stores answer one cycle after rd_en; junk otherwise.
  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= A[a_row][a_col];
      b_data <= B[b_row][b_col];
    end else begin
      a_data <= $urandom();
      b_data <= $urandom();
    end
  end

  typedef struct {
    int row;
    int col;
    logic [DW-1:0] data;
    int cyc;
  } wr_t;

  wr_t wq[$];
  logic [NREQ-1:0] o_grant, o_done;
  int o_lat, o_reads, o_overlap, o_busy_low, o_extra_grant;
  bit o_timeout;
  logic o_busy_after;

  function automatic logic [DW-1:0] ref_c(int i, int j, int m);
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < m; k++) s = s + A[i][k] * B[k][j];
    return s;
  endfunction

  task automatic model_arb(input logic [NREQ-1:0] rv,
                           output logic [NREQ-1:0] exp);
    exp = '0;
    for (int o = 0; o < NREQ; o++) begin
      int idx;
      idx = (tb_ptr + o) % NREQ;
      if (exp == '0 && rv[idx]) begin
        exp = NREQ'(1) << idx;
        tb_ptr = (idx + 1) % NREQ;
      end
    end
  endtask

  task automatic set_dims(input int r, input int n, input int m, input int p);
    req_dims[r*3*DB +: 3*DB] = {DB'(n), DB'(m), DB'(p)};
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        A[i][j] = '0;
        B[i][j] = '0;
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tb_ptr = 0;
  endtask

  task automatic run_job(input logic [NREQ-1:0] reqv, input bit hold);
    int c;
    bit fin;
    wq.delete();
    o_grant = '0; o_done = '0; o_lat = -1; o_reads = 0;
    o_overlap = 0; o_busy_low = 0; o_extra_grant = 0;
    o_timeout = 0; o_busy_after = 1'bx;
    @(posedge clk);
    #1 req = reqv;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (grant == '0 && c < 100);
    if (grant == '0) begin
      o_timeout = 1;
      req = '0;
      return;
    end
    o_grant = grant;
    if (!hold) req = '0;
    c = 0;
    fin = 0;
    while (!fin) begin
      if (rd_en) o_reads++;
      if (c_wr_en) wq.push_back('{int'(c_row), int'(c_col), c_data, c});
      if (rd_en && c_wr_en) o_overlap++;
      if (!busy) o_busy_low++;
      if (c > 0 && grant != '0) o_extra_grant++;
      if (done != '0) begin
        o_done = done;
        o_lat = c;
        fin = 1;
      end else if (c >= 3000) begin
        o_timeout = 1;
        fin = 1;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    @(negedge clk);
    o_busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    req_dims = '0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({grant, done, busy, rd_en, c_wr_en} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {grant, done, busy, rd_en, c_wr_en});
    end
    checks++;
    if ({a_row, a_col, b_row, b_col, c_row, c_col, c_data} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0",
               {a_row, a_col, b_row, b_col, c_row, c_col, c_data});
    end
    reset = 1'b1;
    tb_ptr = 0;
  endtask

  task automatic test_unit();
    logic [NREQ-1:0] exp;
    clear_mem();
    A[0][0] = 3;
    B[0][0] = 5;
    set_dims(0, 1, 1, 1);
    model_arb(2'b01, exp);
    run_job(2'b01, 0);
    checks++;
    if (o_grant !== exp || o_done !== exp) begin
      failures++;
      $display("FAIL unit_grant_done got=%b/%b exp=%b", o_grant, o_done, exp);
    end
    checks++;
    if (o_lat != 3 || o_reads != 1) begin
      failures++;
      $display("FAIL unit_lat_reads got=%0d/%0d exp=3/1", o_lat, o_reads);
    end
    checks++;
    if (wq.size() != 1) begin
      failures++;
      $display("FAIL unit_wr_count got=%0d exp=1", wq.size());
    end else if (wq[0].row != 0 || wq[0].col != 0 || wq[0].data !== 15 ||
                 wq[0].cyc != 2) begin
      failures++;
      $display("FAIL unit_wr got=(%0d,%0d)=%0d@%0d exp=(0,0)=15@2",
               wq[0].row, wq[0].col, wq[0].data, wq[0].cyc);
    end
    checks++;
    if (o_busy_low != 0 || o_busy_after !== 1'b0) begin
      failures++;
      $display("FAIL unit_busy got=%0d/%b exp=0/0", o_busy_low, o_busy_after);
    end
  endtask

  task automatic test_2x2x2();
    logic [NREQ-1:0] exp;
    int er[4];
    int ec[4];
    int ed[4];
    er = '{0, 0, 1, 1};
    ec = '{0, 1, 0, 1};
    ed = '{19, 22, 43, 50};
    clear_mem();
    A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
    B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
    set_dims(1, 2, 2, 2);
    model_arb(2'b10, exp);
    run_job(2'b10, 0);
    checks++;
    if (o_grant !== exp || o_done !== exp) begin
      failures++;
      $display("FAIL m2_grant_done got=%b/%b exp=%b", o_grant, o_done, exp);
    end
    checks++;
    if (o_lat != 20 || o_reads != 8 || wq.size() != 4) begin
      failures++;
      $display("FAIL m2_counts got lat=%0d rd=%0d wr=%0d exp 20/8/4",
               o_lat, o_reads, wq.size());
    end
    for (int w = 0; w < wq.size() && w < 4; w++) begin
      checks++;
      if (wq[w].row != er[w] || wq[w].col != ec[w] || wq[w].data !== DW'(ed[w])) begin
        failures++;
        $display("FAIL m2_wr%0d got=(%0d,%0d)=%0d exp=(%0d,%0d)=%0d", w,
                 wq[w].row, wq[w].col, wq[w].data, er[w], ec[w], ed[w]);
      end
    end
    checks++;
    if (o_overlap != 0) begin
      failures++;
      $display("FAIL m2_overlap got=%0d exp=0", o_overlap);
    end
  endtask

  task automatic test_overflow();
    logic [NREQ-1:0] exp;
    clear_mem();
    A[0][0] = 32'hFFFF_FFFF; A[0][1] = 1;
    B[0][0] = 2; B[1][0] = 3;
    set_dims(0, 1, 2, 1);
    model_arb(2'b01, exp);
    run_job(2'b01, 0);
    checks++;
    if (wq.size() != 1 || o_lat != 5) begin
      failures++;
      $display("FAIL ovf_shape got wr=%0d lat=%0d exp 1/5", wq.size(), o_lat);
    end else if (wq[0].data !== 32'h0000_0001) begin
      failures++;
      $display("FAIL ovf_data got=%h exp=00000001", wq[0].data);
    end
  endtask

  task automatic test_zero_dim();
    logic [NREQ-1:0] exp;
    set_dims(1, 0, 3, 2);
    model_arb(2'b10, exp);
    run_job(2'b10, 0);
    checks++;
    if (o_grant !== exp || o_done !== exp || o_lat != 0) begin
      failures++;
      $display("FAIL zero_pulse got=%b/%b lat=%0d exp=%b lat=0",
               o_grant, o_done, o_lat, exp);
    end
    checks++;
    if (o_reads != 0 || wq.size() != 0 || o_busy_after !== 1'b0) begin
      failures++;
      $display("FAIL zero_quiet got rd=%0d wr=%0d busy=%b exp 0/0/0",
               o_reads, wq.size(), o_busy_after);
    end
  endtask

  task automatic test_arbitration();
    logic [NREQ-1:0] exp;
    logic [NREQ-1:0] seq_exp[3];
    seq_exp = '{2'b01, 2'b10, 2'b01};
    do_reset();
    clear_mem();
    set_dims(0, 1, 1, 1);
    set_dims(1, 1, 1, 2);
    for (int t = 0; t < 3; t++) begin
      model_arb(2'b11, exp);
      run_job(2'b11, t < 2);
      checks++;
      if (o_grant !== seq_exp[t] || o_done !== seq_exp[t]) begin
        failures++;
        $display("FAIL arb%0d got=%b/%b exp=%b", t, o_grant, o_done, seq_exp[t]);
      end
      checks++;
      if (o_extra_grant != 0) begin
        failures++;
        $display("FAIL arb%0d_busy_grant got=%0d exp=0", t, o_extra_grant);
      end
    end
  endtask

  task automatic test_reset_midjob();
    logic [NREQ-1:0] exp;
    int c;
    int bad;
    clear_mem();
    A[0][0] = 7;
    B[0][0] = 9;
    set_dims(0, 3, 3, 3);
    model_arb(2'b01, exp);
    @(posedge clk);
    #1 req = 2'b01;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (grant == '0 && c < 100);
    req = '0;
    checks++;
    if (grant !== exp) begin
      failures++;
      $display("FAIL mid_grant got=%b exp=%b", grant, exp);
    end
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({grant, done, busy, rd_en, c_wr_en, a_row, a_col, b_row, b_col,
         c_row, c_col, c_data} !== '0) begin
      failures++;
      $display("FAIL mid_clear got busy=%b rd=%b wr=%b cdata=%h exp all 0",
               busy, rd_en, c_wr_en, c_data);
    end
    tb_ptr = 0;
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (t == 2) reset = 1'b1;
      if (done != '0 || c_wr_en || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_quiet got=%0d exp=0", bad);
    end
    set_dims(0, 1, 1, 1);
    set_dims(1, 1, 1, 1);
    model_arb(2'b11, exp);
    run_job(2'b11, 0);
    checks++;
    if (o_grant !== 2'b01 || o_done !== exp || o_lat != 3) begin
      failures++;
      $display("FAIL mid_restart got=%b/%b lat=%0d exp=01/%b lat=3",
               o_grant, o_done, o_lat, exp);
    end
    checks++;
    if (wq.size() != 1 || (wq.size() == 1 && wq[0].data !== 63)) begin
      failures++;
      $display("FAIL mid_restart_wr got n=%0d exp 1 write of 63", wq.size());
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] exp;
    logic [NREQ-1:0] rv;
    int dn[NREQ];
    int dm[NREQ];
    int dp[NREQ];
    int w, n, m, p, elat, bad;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          A[i][j] = $urandom();
          B[i][j] = $urandom();
        end
      for (int r = 0; r < NREQ; r++) begin
        dn[r] = $urandom_range(1, 3);
        dm[r] = $urandom_range(1, 4);
        dp[r] = $urandom_range(1, 3);
        if ($urandom_range(0, 7) == 0) dm[r] = 0;
        set_dims(r, dn[r], dm[r], dp[r]);
      end
      rv = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      model_arb(rv, exp);
      w = 0;
      for (int r = 0; r < NREQ; r++) if (exp[r]) w = r;
      n = dn[w]; m = dm[w]; p = dp[w];
      elat = (n * m * p == 0) ? 0 : n * p * (2 * m + 1);
      run_job(rv, 0);
      checks++;
      if (o_timeout || o_grant !== exp || o_done !== exp) begin
        failures++;
        $display("FAIL rnd%0d_arb got=%b/%b to=%0d exp=%b", t,
                 o_grant, o_done, o_timeout, exp);
      end
      checks++;
      if (o_lat != elat || o_reads != n * m * p ||
          wq.size() != ((m == 0) ? 0 : n * p)) begin
        failures++;
        $display("FAIL rnd%0d_counts got lat=%0d rd=%0d wr=%0d exp %0d/%0d/%0d",
                 t, o_lat, o_reads, wq.size(), elat, n * m * p,
                 (m == 0) ? 0 : n * p);
      end
      bad = 0;
      for (int e = 0; e < wq.size(); e++) begin
        if (wq[e].row != e / p || wq[e].col != e % p ||
            wq[e].data !== ref_c(e / p, e % p, m))
          bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL rnd%0d_data got=%0d bad writes exp=0", t, bad);
      end
      checks++;
      if (o_overlap != 0 || o_busy_low != 0 || o_busy_after !== 1'b0) begin
        failures++;
        $display("FAIL rnd%0d_strobes got ov=%0d bl=%0d ba=%b exp 0/0/0", t,
                 o_overlap, o_busy_low, o_busy_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unit();
    test_2x2x2();
    test_overflow();
    test_zero_dim();
    test_arbitration();
    test_reset_midjob();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
